// File: rtl/fp_to_int.sv
// Floating-point to signed integer converter with a one-bit-per-cycle aligning shifter.
// Define FP_TO_INT_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_to_int #(
   parameter int int_size      = 32,
   parameter int precision     = 32,
   parameter int exponent_size = 8,
   parameter int mantissa_size = 23,
   parameter int exp_bias      = 2**(exponent_size-1)-1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [precision-1:0] fp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [int_size-1:0]  int_result,
   output logic                 overflow,
   output logic                 invalid
);

   localparam int WorkWidth = int_size + mantissa_size + 1;
   localparam int ExpWidth  = exponent_size + 2;

   typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

   state_t state, state_next;

   logic                       sign_in;
   logic [exponent_size-1:0]   exp_field;
   logic [mantissa_size-1:0]   man_field;
   logic signed [ExpWidth-1:0] e_unb;
   logic signed [ExpWidth-1:0] shift_amt;
   logic [ExpWidth-1:0]        shift_mag;
   logic                       is_special;
   logic                       is_zero;
   logic                       is_ovf;

   logic                       sign_q;
   logic                       shift_left;
   logic [WorkWidth-1:0]       work;
   logic [ExpWidth-1:0]        cnt;

   assign sign_in   = fp[precision-1];
   assign exp_field = fp[precision-2 -: exponent_size];
   assign man_field = fp[mantissa_size-1:0];
   assign e_unb     = $signed({2'b00, exp_field}) - $signed(ExpWidth'(exp_bias));
   assign shift_amt = e_unb - $signed(ExpWidth'(mantissa_size));
   assign shift_mag = shift_amt[ExpWidth-1] ? ExpWidth'(-shift_amt) : ExpWidth'(shift_amt);

   // Early-out classes resolved at accept; is_ovf leaves the exact most-negative value to the normal path.
   assign is_special = &exp_field;
   assign is_zero    = (exp_field == '0) || (e_unb < 0);
   assign is_ovf     = (e_unb > $signed(ExpWidth'(int_size-1))) ||
                       ((e_unb == $signed(ExpWidth'(int_size-1))) && (!sign_in || (man_field != '0)));

`ifdef FP_TO_INT_ROUND_EN
   logic                guard;
   logic                sticky;
   logic                round_up;
   logic [int_size:0]   mag_round;
   logic                round_ovf;

   assign round_up  = guard && (sticky || work[0]);
   assign mag_round = {1'b0, work[int_size-1:0]} + (int_size+1)'(round_up);
   assign round_ovf = !sign_q && (|mag_round[int_size:int_size-1]);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_special || is_zero || is_ovf) begin
                  state_next = DONE;
               end else if (shift_mag == '0) begin
                  state_next = SIGN;
               end else begin
                  state_next = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (cnt == ExpWidth'(1)) begin
               state_next = SIGN;
            end
         end
         SIGN: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: load and classify on accept, align in SHIFT, apply sign in SIGN, hold through DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         int_result <= '0;
         overflow   <= 1'b0;
         invalid    <= 1'b0;
         sign_q     <= 1'b0;
         shift_left <= 1'b0;
         work       <= '0;
         cnt        <= '0;
`ifdef FP_TO_INT_ROUND_EN
         guard      <= 1'b0;
         sticky     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q     <= sign_in;
                  overflow   <= 1'b0;
                  invalid    <= 1'b0;
                  work       <= WorkWidth'({1'b1, man_field});
                  cnt        <= shift_mag;
                  shift_left <= !shift_amt[ExpWidth-1];
`ifdef FP_TO_INT_ROUND_EN
                  guard      <= 1'b0;
                  sticky     <= 1'b0;
`endif
                  if (is_special) begin
                     invalid    <= 1'b1;
                     int_result <= {1'b1, {(int_size-1){1'b0}}};
                  end else if (is_zero) begin
                     int_result <= '0;
                  end else if (is_ovf) begin
                     overflow   <= 1'b1;
                     int_result <= sign_in ? {1'b1, {(int_size-1){1'b0}}}
                                           : {1'b0, {(int_size-1){1'b1}}};
                  end
               end
            end
            SHIFT: begin
               work <= shift_left ? (work << 1) : (work >> 1);
               cnt  <= cnt - ExpWidth'(1);
`ifdef FP_TO_INT_ROUND_EN
               if (!shift_left) begin
                  guard  <= work[0];
                  sticky <= sticky | guard;
               end
`endif
            end
            SIGN: begin
`ifdef FP_TO_INT_ROUND_EN
               if (round_ovf) begin
                  overflow   <= 1'b1;
                  int_result <= {1'b0, {(int_size-1){1'b1}}};
               end else begin
                  int_result <= sign_q ? -mag_round[int_size-1:0] : mag_round[int_size-1:0];
               end
`else
               int_result <= sign_q ? -work[int_size-1:0] : work[int_size-1:0];
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed corner cases, randomized vectors against an
// arithmetic reference model, backpressure hold and reset during a conversion.
module tb_fp_to_int;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] fp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] int_result;
   logic        overflow;
   logic        invalid;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] f;
      logic [31:0] v;
      logic        o;
      logic        i;
      int          lat;
   } vec_t;

   always #5 clk = ~clk;

   fp_to_int dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fp         (fp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .int_result (int_result),
      .overflow   (overflow),
      .invalid    (invalid)
   );

   // Every comparison goes through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Value = 1.mantissa * 2^(exp-127), reduced to an integer with plain arithmetic.
   function automatic void refModel(input logic [31:0] f, output logic [31:0] value,
                                    output logic ovf, output logic inv, output int lat);
      longint sig, mag, limit;
      longint rem, half;
      int     e;
      e     = int'(f[30:23]) - 127;
      sig   = longint'({1'b1, f[22:0]});
      limit = f[31] ? 64'sd2147483648 : 64'sd2147483647;
      value = 32'h0;
      ovf   = 1'b0;
      inv   = 1'b0;
      lat   = 1;
      rem   = 0;
      half  = 0;
      if (f[30:23] == 8'hFF) begin
         inv   = 1'b1;
         value = 32'h8000_0000;
      end else if (f[30:23] == 8'h00 || e < 0) begin
         value = 32'h0;
      end else if (e > 31) begin
         ovf   = 1'b1;
         value = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         if (e >= 23) begin
            mag = sig <<< (e - 23);
         end else begin
            mag  = sig >>> (23 - e);
            rem  = sig - (mag <<< (23 - e));
            half = 64'sd1 <<< (22 - e);
         end
         if (mag > limit) begin
            ovf   = 1'b1;
            value = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end else begin
            lat = ((e >= 23) ? (e - 23) : (23 - e)) + 2;
`ifdef FP_TO_INT_ROUND_EN
            if (e < 23 && (rem > half || (rem == half && mag[0]))) mag = mag + 1;
`endif
            if (mag > limit) begin
               ovf   = 1'b1;
               value = 32'h7FFF_FFFF;
            end else begin
               value = f[31] ? 32'(-mag) : 32'(mag);
            end
         end
      end
   endfunction

   // Present one word, wait (bounded) for the result; latency -1 means it never came.
   task automatic applyStimulus(input logic [31:0] value, output int latency);
      @(negedge clk);
      fp       = value;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      latency  = 1;
      while (!out_valid && latency < 100) begin
         @(negedge clk);
         latency++;
      end
      if (!out_valid) latency = -1;
   endtask

   task automatic runVector(input string tag, input logic [31:0] f, input logic [31:0] v,
                            input logic o, input logic i, input int lat);
      int got_lat;
      applyStimulus(f, got_lat);
      checkOutput({tag, ".lat"}, 32'(got_lat), 32'(lat));
      checkOutput({tag, ".int"}, int_result, v);
      checkOutput({tag, ".ovf"}, {31'b0, overflow}, {31'b0, o});
      checkOutput({tag, ".inv"}, {31'b0, invalid}, {31'b0, i});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, ".rdy"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      vec_t        dir [$];
      logic [31:0] rv, exp_v;
      logic        exp_o, exp_i;
      int          exp_lat, lat;
      logic [31:0] held;
      logic        seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      fp        = 32'h0;
      repeat (2) @(negedge clk);
      checkOutput("reset.in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("reset.out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset.int",       int_result,         32'd0);
      checkOutput("reset.ovf",       {31'b0, overflow},  32'd0);
      checkOutput("reset.inv",       {31'b0, invalid},   32'd0);
      reset = 1'b0;

      dir.push_back('{32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 22});
      dir.push_back('{32'hC120_0000, 32'hFFFF_FFF6, 1'b0, 1'b0, 22});
      dir.push_back('{32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 9});
      dir.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1});
      dir.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 10});
      dir.push_back('{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 1});
      dir.push_back('{32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1});
      dir.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1});
      dir.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1});
      dir.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1});
      dir.push_back('{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2});
`ifdef FP_TO_INT_ROUND_EN
      dir.push_back('{32'h4060_0000, 32'h0000_0004, 1'b0, 1'b0, 24});
      dir.push_back('{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b0, 24});
      dir.push_back('{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 25});
`else
      dir.push_back('{32'h4060_0000, 32'h0000_0003, 1'b0, 1'b0, 24});
      dir.push_back('{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b0, 24});
      dir.push_back('{32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 25});
`endif
      foreach (dir[k]) begin
         runVector($sformatf("dir%0d", k), dir[k].f, dir[k].v, dir[k].o, dir[k].i, dir[k].lat);
      end

      for (int n = 0; n < 150; n++) begin
         rv[31]    = 1'($urandom_range(0, 1));
         rv[30:23] = (n % 25 == 0) ? 8'hFF : (n % 25 == 1) ? 8'h00 : 8'($urandom_range(120, 162));
         rv[22:0]  = 23'($urandom);
         refModel(rv, exp_v, exp_o, exp_i, exp_lat);
         runVector($sformatf("rnd%0d_%h", n, rv), rv, exp_v, exp_o, exp_i, exp_lat);
      end

      // Result must sit unchanged while the consumer stalls, and new inputs must be refused.
      applyStimulus(32'h4120_0000, lat);
      checkOutput("bp.lat", 32'(lat), 32'd22);
      held     = int_result;
      fp       = 32'h4F00_0000;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("bp%0d.int", c), int_result, 32'h0000_000A);
         checkOutput($sformatf("bp%0d.ovf", c), {31'b0, overflow}, 32'd0);
         checkOutput($sformatf("bp%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
         checkOutput($sformatf("bp%0d.out_valid", c), {31'b0, out_valid}, 32'd1);
      end
      checkOutput("bp.held", int_result, held);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("bp.release.in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("bp.release.out_valid", {31'b0, out_valid}, 32'd0);

      // Reset in the middle of alignment abandons the conversion silently.
      @(negedge clk);
      fp       = 32'h4120_0000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset.in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("midreset.out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midreset.int",       int_result,         32'd0);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checkOutput("midreset.no_output", {31'b0, seen}, 32'd0);

      runVector("post_reset", 32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 9);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
